// File: rtl/fir_pkg.sv
// Shared FIR datapath types and default widths.
// prod_width also sizes the downstream accumulator (ACCUBITS = MULTBITS + $clog2(TAPS)).
package fir_pkg;

  localparam int DEF_TAPS     = 8;
  localparam int DEF_DATABITS = 16;
  localparam int DEF_COEFBITS = 16;

  function automatic int prod_width(input int databits, input int coefbits);
    return databits + coefbits;
  endfunction

  localparam int DEF_MULTBITS = prod_width(DEF_DATABITS, DEF_COEFBITS);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fill_state_t;

endpackage

// File: rtl/fir_tap_multiplier_if.sv
// Sample, coefficient-write and product bundle between the FIR front end and its neighbours.
// master drives samples/coefficients, slave is the multiplier stage.
interface fir_tap_multiplier_if
  import fir_pkg::*;
#(
  parameter int TAPS     = DEF_TAPS,
  parameter int DATABITS = DEF_DATABITS,
  parameter int COEFBITS = DEF_COEFBITS,
  parameter int MULTBITS = DEF_MULTBITS
);

  localparam int AW = $clog2(TAPS);

  logic                       in_valid;
  logic signed [DATABITS-1:0] sample_in;
  logic                       clear;
  logic                       coef_wr_en;
  logic [AW-1:0]              coef_wr_addr;
  logic signed [COEFBITS-1:0] coef_wr_data;
  logic signed [MULTBITS-1:0] multiplier_out [0:TAPS-1];
  logic                       out_valid;
  logic                       primed;

  modport master (
    output in_valid, sample_in, clear, coef_wr_en, coef_wr_addr, coef_wr_data,
    input  multiplier_out, out_valid, primed
  );

  modport slave (
    input  in_valid, sample_in, clear, coef_wr_en, coef_wr_addr, coef_wr_data,
    output multiplier_out, out_valid, primed
  );

endinterface

// File: rtl/fir_delay_line.sv
// TAPS-deep sample shift register; shifts on shift_en, synchronous clear zeroes every stage.
// clear has priority over shift_en so a sample arriving with clear is dropped.
module fir_delay_line #(
  parameter int TAPS     = 8,
  parameter int DATABITS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       shift_en,
  input  logic                       clear,
  input  logic signed [DATABITS-1:0] sample_in,
  output logic signed [DATABITS-1:0] taps [0:TAPS-1]
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) taps[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < TAPS; k++) taps[k] <= '0;
    end else if (shift_en) begin
      taps[0] <= sample_in;
      for (int k = 1; k < TAPS; k++) taps[k] <= taps[k-1];
    end
  end

endmodule

// File: rtl/fir_tap_multiplier.sv
// FIR front half: delay line, writable coefficient bank and one registered product per tap.
// Products land one edge after a sample is accepted; no backpressure, one sample per cycle.
module fir_tap_multiplier
  import fir_pkg::*;
#(
  parameter int TAPS     = DEF_TAPS,
  parameter int DATABITS = DEF_DATABITS,
  parameter int COEFBITS = DEF_COEFBITS,
  parameter int MULTBITS = DEF_MULTBITS
) (
  input  logic           clk,
  input  logic           rst,
  fir_tap_multiplier_if.slave bus
);

  localparam int CW = $clog2(TAPS + 1);

  if (TAPS < 2) begin : g_bad_taps
    $error("fir_tap_multiplier: TAPS must be at least 2");
  end
  if (MULTBITS != prod_width(DATABITS, COEFBITS)) begin : g_bad_multbits
    $error("fir_tap_multiplier: MULTBITS must equal DATABITS+COEFBITS");
  end

  logic                       accept;
  logic signed [DATABITS-1:0] d    [0:TAPS-1];
  logic signed [COEFBITS-1:0] c    [0:TAPS-1];
  logic signed [MULTBITS-1:0] prod [0:TAPS-1];
  logic                       pend;
  logic                       out_valid_q;
  fill_state_t                state;
  logic [CW-1:0]              fill_cnt;

  assign accept = bus.in_valid && !bus.clear;

  fir_delay_line #(
    .TAPS     (TAPS),
    .DATABITS (DATABITS)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (bus.in_valid),
    .clear     (bus.clear),
    .sample_in (bus.sample_in),
    .taps      (d)
  );

  // Out-of-range addresses only exist when TAPS is not a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) c[k] <= '0;
    end else if (bus.coef_wr_en && (int'(bus.coef_wr_addr) < TAPS)) begin
      c[bus.coef_wr_addr] <= bus.coef_wr_data;
    end
  end

  // d and c already reflect the accepting edge, so a same-edge coefficient write is honoured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend        <= 1'b0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) prod[k] <= '0;
    end else begin
      pend        <= accept;
      out_valid_q <= pend;
      if (pend) begin
        for (int k = 0; k < TAPS; k++) prod[k] <= MULTBITS'(d[k]) * MULTBITS'(c[k]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      fill_cnt <= '0;
    end else if (bus.clear) begin
      state    <= FILL;
      fill_cnt <= '0;
    end else if (bus.in_valid) begin
      case (state)
        FILL: begin
          fill_cnt <= fill_cnt + CW'(1);
          if (fill_cnt == CW'(TAPS - 1)) state <= RUN;
        end
        default: fill_cnt <= CW'(TAPS);
      endcase
    end
  end

  assign bus.multiplier_out = prod;
  assign bus.out_valid      = out_valid_q;
  assign bus.primed         = (state == RUN);

endmodule

// File: doc/fir_tap_multiplier.md
# fir_tap_multiplier

Front half of the FIR datapath. It holds a TAPS-deep sample delay line and a writable coefficient bank, and produces one registered signed product per tap each time a sample is accepted. It feeds `accumulator` directly: `multiplier_out` and `out_valid` connect to the accumulator's `multiplier_out` and `in_valid`.

## Interface
- `TAPS`, 8, number of taps; must be ≥ 2.
- `DATABITS`, 16, signed sample width.
- `COEFBITS`, 16, signed coefficient width.
- `MULTBITS`, 32, product width; elaboration error unless it equals DATABITS+COEFBITS.

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: `sample_in` is accepted on this edge.
- `sample_in` in DATABITS: signed input sample.
- `clear` in 1: synchronous flush of the delay line.
- `coef_wr_en` in 1: write strobe for the coefficient bank.
- `coef_wr_addr` in $clog2(TAPS): tap index to write.
- `coef_wr_data` in COEFBITS: signed coefficient value.
- `multiplier_out` out MULTBITS × [0:TAPS-1]: registered products; tap k = sample delayed k × coef[k].
- `out_valid` out 1: one-cycle pulse marking a new product set.
- `primed` out 1: high once TAPS samples have entered since reset or the last clear.

## Operation
- Delay line `d[0:TAPS-1]`:
  - On an `in_valid` edge: `d[0]` ← `sample_in` and `d[k]` ← `d[k-1]`.
  - Otherwise the delay line holds.
- Coefficient bank `c[0:TAPS-1]`:
  - On a `coef_wr_en` edge: `c[coef_wr_addr]` ← `coef_wr_data`.
  - An address ≥ TAPS is ignored.
  - Writes are independent of `in_valid` and `clear`.
- Product stage:
  - On the edge after an accepted sample: `multiplier_out[k]` ← signed(`d[k]`) × signed(`c[k]`), full precision with no truncation or saturation.
  - `out_valid` ← 1 on that edge; otherwise `out_valid` ← 0.
  - `multiplier_out` holds its value when no new set is produced.
- Fill FSM, states FILL and RUN, with counter `fill_cnt` in 0..TAPS:
  - FILL: each accepted sample increments `fill_cnt`; on reaching TAPS, go to RUN.
  - RUN: `fill_cnt` saturates at TAPS. `primed` = (state == RUN).
- `clear`:
  - Zeroes `d`, resets `fill_cnt` to 0 and returns the FSM to FILL.
  - Coefficients and `multiplier_out` are left unchanged.
  - `clear` together with `in_valid`: `clear` wins and the sample is discarded. No product set is generated from that edge.
- Coefficient write on the same edge as `in_valid`: the new coefficient is used for the product set that sample generates.
- Products during FILL are valid FIR partials against zeroed history. `out_valid` is not gated by `primed`.

## Timing
- Reset values (asynchronous, immediate): `d` = 0, `c` = 0, `multiplier_out` = all 0, `out_valid` = 0, `primed` = 0, FSM = FILL, `fill_cnt` = 0.
- Latency: `in_valid` sampled at edge E0 → products registered and `out_valid` high at E1, low at E2 unless another sample arrived at E1.
- Throughput: one sample per cycle. Back-to-back `in_valid` yields back-to-back `out_valid`.
- `primed` rises on the edge that accepts the TAPS-th sample, one cycle before that sample's products appear.
- `rst` asserted mid-stream: everything returns to its reset value immediately, and any pending `out_valid` is lost.

## Structure
- Package `fir_pkg`:
  - default DATABITS, COEFBITS, MULTBITS and TAPS;
  - the `fill_state_t` enum {FILL, RUN};
  - a `prod_width` function (DATABITS+COEFBITS), reused by `accumulator` for ACCUBITS = MULTBITS + $clog2(TAPS).
- One sub-module: `fir_delay_line` (shift register with enable and synchronous clear, parameterised by TAPS and DATABITS).
- Products and FSM live in the top level.

## Test plan
- Reset, then write c[k] = k+1 and push sample 1 followed by zeros → on successive `out_valid` pulses, the product at tap k is k+1 at the k-th pulse and 0 elsewhere. `primed` rises with the 8th sample.
- Signed extremes: c[0] = −32768, sample −32768 → `multiplier_out[0]` = 32'h4000_0000. Sample 32767 with c[0] = −1 → 32'hFFFF_8001.
- `in_valid` held high for 20 cycles → 20 consecutive `out_valid` cycles, each one edge after its sample. Gaps in `in_valid` reproduce the same gaps in `out_valid`.
- `clear` and `in_valid` on the same edge after priming → no `out_valid` next cycle, `primed` = 0, and the next sample's products show only tap 0 nonzero.
- Coefficient write to tap 3 on the same edge as `in_valid` → that set's `multiplier_out[3]` uses the new value. Write to address ≥ TAPS (only when TAPS is not a power of 2) → bank unchanged.
- `rst` pulsed between `in_valid` and the expected `out_valid` → `out_valid` stays 0, all outputs 0, and the FSM is in FILL afterwards.
